// File: rtl/pieo_op_sequencer.sv
// pieo_op_sequencer: front-end controller for the PIEO sorted-list core.
// It serialises enqueue requests (round-robin over NUM_ENQ ports) and
// scheduler dequeues into one core operation at a time. It also tracks
// occupancy against LIST_SIZE and bounds every core operation with a
// timeout.
module pieo_op_sequencer #(
  parameter int ELEM_W    = 18,
  parameter int TIME_LOG  = 6,
  parameter int LIST_SIZE = 4,
  parameter int NUM_ENQ   = 2,
  parameter int MAX_WAIT  = 15
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_ENQ-1:0]                enq_valid,
  input  logic [NUM_ENQ*ELEM_W-1:0]         enq_elem,
  output logic [NUM_ENQ-1:0]                enq_ready,
  input  logic                              deq_req,
  input  logic [TIME_LOG-1:0]               deq_time,
  output logic                              deq_ack,
  output logic                              deq_resp_valid,
  output logic                              deq_resp_found,
  output logic [ELEM_W-1:0]                 deq_resp_elem,
  output logic                              core_start,
  output logic                              core_is_enq,
  output logic [ELEM_W-1:0]                 core_elem,
  output logic [TIME_LOG-1:0]               core_time,
  input  logic                              core_done,
  input  logic                              core_found,
  input  logic [ELEM_W-1:0]                 core_elem_out,
  output logic [$clog2(LIST_SIZE+1)-1:0]    occupancy,
  output logic                              full,
  output logic                              empty,
  output logic                              timeout_err
);
  localparam int OCC_W = $clog2(LIST_SIZE+1);
  localparam int PTR_W = (NUM_ENQ > 1) ? $clog2(NUM_ENQ) : 1;
  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT+1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state, state_n;
  logic [PTR_W-1:0]   rr_ptr, grant_idx;
  logic               grant_vld, take_deq, take_enq;
  logic               wait_done, expired;
  logic [OCC_W-1:0]   occ_n;
  logic [CNT_W-1:0]   wait_cnt;
  logic               resp_found_q;
  logic [ELEM_W-1:0]  resp_elem_q;

  // done only counts while waiting; expiry loses to a same-cycle done
  assign wait_done = (state == WAIT) && core_done;
  assign expired   = (state == WAIT) && !core_done &&
                     (wait_cnt == CNT_W'(MAX_WAIT-1));

  // round-robin search: first valid requester at or after rr_ptr
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_ENQ; k++) begin
      if (!grant_vld && enq_valid[(int'(rr_ptr) + k) % NUM_ENQ]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'((int'(rr_ptr) + k) % NUM_ENQ);
      end
    end
  end

  // next-state: dequeue beats enqueue, one core op in flight at most
  always_comb begin
    state_n  = state;
    take_deq = 1'b0;
    take_enq = 1'b0;
    case (state)
      IDLE: begin
        if (deq_req) begin
          take_deq = 1'b1;
          state_n  = empty ? RESP : ISSUE;
        end else if (grant_vld && !full) begin
          take_enq = 1'b1;
          state_n  = ISSUE;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (wait_done || expired) state_n = core_is_enq ? IDLE : RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // occupancy update on completion, saturating at both ends
  always_comb begin
    occ_n = occupancy;
    if (wait_done) begin
      if (core_is_enq) begin
        if (occupancy != OCC_W'(LIST_SIZE)) occ_n = occupancy + 1'b1;
      end else if (core_found && (occupancy != '0)) begin
        occ_n = occupancy - 1'b1;
      end
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // request side: grants, acks, latched operands, rr pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enq_ready   <= '0;
      deq_ack     <= 1'b0;
      core_start  <= 1'b0;
      core_is_enq <= 1'b0;
      core_elem   <= '0;
      core_time   <= '0;
      rr_ptr      <= '0;
    end else begin
      enq_ready  <= '0;
      deq_ack    <= take_deq;
      core_start <= (state_n == ISSUE);
      if (take_enq) begin
        enq_ready[grant_idx] <= 1'b1;
        core_is_enq          <= 1'b1;
        core_elem            <= enq_elem[grant_idx*ELEM_W +: ELEM_W];
        rr_ptr <= (grant_idx == PTR_W'(NUM_ENQ-1)) ? '0 : grant_idx + 1'b1;
      end else if (take_deq) begin
        core_is_enq <= 1'b0;
        core_time   <= deq_time;
      end
    end
  end

  // core side: wait counter, result capture, occupancy, sticky timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt     <= '0;
      resp_found_q <= 1'b0;
      resp_elem_q  <= '0;
      occupancy    <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      timeout_err  <= 1'b0;
    end else begin
      if (state == ISSUE)                          wait_cnt <= '0;
      else if (state == WAIT && state_n == WAIT)   wait_cnt <= wait_cnt + 1'b1;
      if (take_deq && empty) begin
        resp_found_q <= 1'b0;
      end else if (wait_done && !core_is_enq) begin
        resp_found_q <= core_found;
        resp_elem_q  <= core_elem_out;
      end else if (expired && !core_is_enq) begin
        resp_found_q <= 1'b0;
      end
      occupancy   <= occ_n;
      full        <= (occ_n == OCC_W'(LIST_SIZE));
      empty       <= (occ_n == '0);
      timeout_err <= timeout_err | expired;
    end
  end

  // response pulse, element zeroed when nothing was found
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deq_resp_valid <= 1'b0;
      deq_resp_found <= 1'b0;
      deq_resp_elem  <= '0;
    end else begin
      deq_resp_valid <= (state == RESP);
      deq_resp_found <= (state == RESP) && resp_found_q;
      deq_resp_elem  <= ((state == RESP) && resp_found_q) ? resp_elem_q : '0;
    end
  end
endmodule

// File: tb/tb_pieo_op_sequencer.sv
// Directed bench for pieo_op_sequencer with a behavioural core model
// whose latency and dequeue result are set per operation.
module tb_pieo_op_sequencer;
  localparam int ELEM_W = 18, TIME_LOG = 6, LIST_SIZE = 4, NUM_ENQ = 2, MAX_WAIT = 15;

  logic                      clk = 1'b0, rst = 1'b1;
  logic [NUM_ENQ-1:0]        enq_valid = '0;
  logic [NUM_ENQ*ELEM_W-1:0] enq_elem = '0;
  logic [NUM_ENQ-1:0]        enq_ready;
  logic                      deq_req = 1'b0;
  logic [TIME_LOG-1:0]       deq_time = '0;
  logic                      deq_ack, deq_resp_valid, deq_resp_found;
  logic [ELEM_W-1:0]         deq_resp_elem;
  logic                      core_start, core_is_enq;
  logic [ELEM_W-1:0]         core_elem;
  logic [TIME_LOG-1:0]       core_time;
  logic                      core_done = 1'b0, core_found = 1'b0;
  logic [ELEM_W-1:0]         core_elem_out = '0;
  logic [2:0]                occupancy;
  logic                      full, empty, timeout_err;

  pieo_op_sequencer #(.ELEM_W(ELEM_W), .TIME_LOG(TIME_LOG), .LIST_SIZE(LIST_SIZE),
                      .NUM_ENQ(NUM_ENQ), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_elem(enq_elem), .enq_ready(enq_ready),
    .deq_req(deq_req), .deq_time(deq_time), .deq_ack(deq_ack),
    .deq_resp_valid(deq_resp_valid), .deq_resp_found(deq_resp_found),
    .deq_resp_elem(deq_resp_elem), .core_start(core_start), .core_is_enq(core_is_enq),
    .core_elem(core_elem), .core_time(core_time), .core_done(core_done),
    .core_found(core_found), .core_elem_out(core_elem_out), .occupancy(occupancy),
    .full(full), .empty(empty), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int core_lat = 1, pend_cnt = 0, start_cnt = 0;
  logic              cfg_found = 1'b0;
  logic [ELEM_W-1:0] cfg_elem = '0;

  // core model: done pulse core_lat cycles after the start cycle (0 = never)
  initial begin
    forever begin
      @(negedge clk);
      core_done = 1'b0; core_found = 1'b0; core_elem_out = '0;
      if (rst) pend_cnt = 0;
      else begin
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            core_done = 1'b1; core_found = cfg_found; core_elem_out = cfg_elem;
          end
        end
        if (core_start) begin start_cnt++; pend_cnt = core_lat; end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enq_valid = '0; deq_req = 1'b0; deq_time = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_enq(input int req, input logic [ELEM_W-1:0] elem, input int lat,
                        input int exp_occ);
    int n;
    core_lat = lat;
    enq_valid[req] = 1'b1;
    enq_elem[req*ELEM_W +: ELEM_W] = elem;
    n = 0;
    do begin @(negedge clk); n++; end while (enq_ready == '0 && n < 20);
    chk("enq_grant", 32'(enq_ready), 32'(1 << req));
    chk("enq_core_start", 32'(core_start), 32'd1);
    chk("enq_is_enq", 32'(core_is_enq), 32'd1);
    chk("enq_core_elem", 32'(core_elem), 32'(elem));
    enq_valid[req] = 1'b0;
    @(negedge clk);
    chk("enq_ready_pulse", 32'(enq_ready), 32'd0);
    chk("enq_start_pulse", 32'(core_start), 32'd0);
    repeat (lat) @(negedge clk);
    chk("enq_occ", 32'(occupancy), 32'(exp_occ));
    chk("enq_empty", 32'(empty), 32'(exp_occ == 0));
  endtask

  task automatic do_deq(input logic [TIME_LOG-1:0] t, input int lat, input logic cf,
                        input logic [ELEM_W-1:0] ce, input logic ef,
                        input logic [ELEM_W-1:0] ee, input int exp_occ, input bit was_empty);
    int n, s0, exp_lat;
    core_lat = lat; cfg_found = cf; cfg_elem = ce; s0 = start_cnt;
    deq_req = 1'b1; deq_time = t;
    @(negedge clk);
    chk("deq_ack", 32'(deq_ack), 32'd1);
    deq_req = 1'b0; deq_time = '0;
    if (!was_empty) begin
      chk("deq_core_start", 32'(core_start), 32'd1);
      chk("deq_is_enq", 32'(core_is_enq), 32'd0);
    end
    exp_lat = was_empty ? 1 : ((lat == 0 || lat > MAX_WAIT) ? MAX_WAIT + 2 : lat + 2);
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1 && !was_empty) chk("deq_core_time", 32'(core_time), 32'(t));
    end while (!deq_resp_valid && n < 40);
    chk("deq_latency", n, exp_lat);
    chk("deq_found", 32'(deq_resp_found), 32'(ef));
    chk("deq_elem", 32'(deq_resp_elem), 32'(ee));
    chk("deq_occ", 32'(occupancy), 32'(exp_occ));
    if (was_empty) chk("deq_no_core_op", start_cnt, s0);
    @(negedge clk);
    chk("deq_resp_pulse", 32'(deq_resp_valid), 32'd0);
  endtask

  typedef struct {
    bit                is_enq;
    int                req;
    logic [ELEM_W-1:0] elem;
    logic [5:0]        t;
    int                lat;
    logic              cfound;
    logic [ELEM_W-1:0] celem;
    logic              exp_found;
    logic [ELEM_W-1:0] exp_elem;
    int                exp_occ;
    bit                was_empty;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n, g, busy;
    logic [1:0] grants[4];

    vecs[0] = '{0, 0, 18'h0,     6'h00, 2, 1'b1, 18'h3FFFF, 1'b0, 18'h0,     0, 1};
    vecs[1] = '{1, 0, 18'h2A5C,  6'h00, 3, 1'b0, 18'h0,     1'b0, 18'h0,     1, 0};
    vecs[2] = '{1, 1, 18'h1F0,   6'h00, 1, 1'b0, 18'h0,     1'b0, 18'h0,     2, 0};
    vecs[3] = '{0, 0, 18'h0,     6'h01, 2, 1'b1, 18'h1F0,   1'b1, 18'h1F0,   1, 0};
    vecs[4] = '{0, 0, 18'h0,     6'h01, 4, 1'b0, 18'h12345, 1'b0, 18'h0,     1, 0};
    vecs[5] = '{1, 0, 18'h3ABCD, 6'h00, 5, 1'b0, 18'h0,     1'b0, 18'h0,     2, 0};
    vecs[6] = '{0, 0, 18'h0,     6'h2A, 1, 1'b1, 18'h3ABCD, 1'b1, 18'h3ABCD, 1, 0};
    vecs[7] = '{0, 0, 18'h0,     6'h3F, 3, 1'b1, 18'h2A5C,  1'b1, 18'h2A5C,  0, 0};
    vecs[8] = '{0, 0, 18'h0,     6'h05, 1, 1'b1, 18'h11,    1'b0, 18'h0,     0, 1};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_enq_ready", 32'(enq_ready), 0);
    chk("rst_deq_ack", 32'(deq_ack), 0);
    chk("rst_resp_valid", 32'(deq_resp_valid), 0);
    chk("rst_core_start", 32'(core_start), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_timeout", 32'(timeout_err), 0);
    rst = 1'b0;
    @(negedge clk);

    // table-driven operation sequence
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_enq) do_enq(vecs[i].req, vecs[i].elem, vecs[i].lat, vecs[i].exp_occ);
      else do_deq(vecs[i].t, vecs[i].lat, vecs[i].cfound, vecs[i].celem, vecs[i].exp_found,
                  vecs[i].exp_elem, vecs[i].exp_occ, vecs[i].was_empty);
    end

    // round-robin fill, then hold-off while full
    do_reset();
    core_lat = 1;
    enq_elem = {18'h00B0B, 18'h00A0A};
    enq_valid = 2'b11;
    g = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (enq_ready != '0) begin
        if (g < 4) grants[g] = enq_ready;
        g++;
      end
    end
    chk("rr_grant_count", g, 4);
    chk("rr_g0", 32'(grants[0]), 32'd1);
    chk("rr_g1", 32'(grants[1]), 32'd2);
    chk("rr_g2", 32'(grants[2]), 32'd1);
    chk("rr_g3", 32'(grants[3]), 32'd2);
    chk("fill_occ", 32'(occupancy), 4);
    chk("fill_full", 32'(full), 1);
    enq_valid = 2'b01;
    busy = 0;
    repeat (6) begin @(negedge clk); if (enq_ready != '0) busy++; end
    chk("full_holdoff", busy, 0);
    do_deq(6'h01, 1, 1'b1, 18'h00A0A, 1'b1, 18'h00A0A, 3, 0);
    chk("held_enq_granted", 32'(enq_ready), 32'd1);
    enq_valid = '0;
    repeat (2) @(negedge clk);
    chk("refill_occ", 32'(occupancy), 4);
    chk("refill_full", 32'(full), 1);

    // dequeue raised together with enqueue wins
    do_reset();
    do_enq(0, 18'h00123, 1, 1);
    core_lat = 2; cfg_found = 1'b1; cfg_elem = 18'h00123;
    deq_req = 1'b1; deq_time = 6'h02; enq_valid = 2'b10; enq_elem[ELEM_W +: ELEM_W] = 18'h00456;
    @(negedge clk);
    chk("prio_deq_ack", 32'(deq_ack), 1);
    chk("prio_enq_blocked", 32'(enq_ready), 0);
    deq_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!deq_resp_valid && n < 40);
    chk("prio_resp_found", 32'(deq_resp_found), 1);
    n = 0;
    do begin @(negedge clk); n++; end while (enq_ready == '0 && n < 20);
    chk("prio_enq_after", 32'(enq_ready), 32'd2);
    enq_valid = '0;
    repeat (3) @(negedge clk);
    chk("prio_occ", 32'(occupancy), 1);

    // done on the last wait cycle wins over expiry, then a real timeout
    do_reset();
    do_enq(1, 18'h0BEEF, MAX_WAIT, 1);
    chk("edge_no_timeout", 32'(timeout_err), 0);
    core_lat = 0;
    enq_valid[0] = 1'b1; enq_elem[ELEM_W-1:0] = 18'h0DEAD;
    n = 0;
    do begin @(negedge clk); n++; end while (enq_ready == '0 && n < 20);
    chk("to_enq_grant", 32'(enq_ready), 1);
    enq_valid = '0;
    repeat (MAX_WAIT) @(negedge clk);
    chk("to_not_yet", 32'(timeout_err), 0);
    @(negedge clk);
    chk("to_set", 32'(timeout_err), 1);
    chk("to_enq_not_counted", 32'(occupancy), 1);
    do_deq(6'h03, 0, 1'b1, 18'h1, 1'b0, 18'h0, 1, 0);
    do_deq(6'h04, 2, 1'b1, 18'h0BEEF, 1'b1, 18'h0BEEF, 0, 0);
    chk("to_sticky", 32'(timeout_err), 1);

    // reset during an outstanding dequeue discards it
    do_enq(0, 18'h00777, 1, 1);
    core_lat = 0;
    deq_req = 1'b1; deq_time = 6'h07;
    @(negedge clk);
    chk("mid_deq_ack", 32'(deq_ack), 1);
    deq_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_occ", 32'(occupancy), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_timeout", 32'(timeout_err), 0);
    chk("mid_rst_start", 32'(core_start), 0);
    rst = 1'b0;
    busy = 0;
    repeat (25) begin @(negedge clk); if (deq_resp_valid || core_start) busy++; end
    chk("mid_rst_discard", busy, 0);
    chk("mid_rst_no_timeout", 32'(timeout_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // absolute time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pieo_op_sequencer.md
Name: pieo_op_sequencer

Overview:
- Front-end controller for the PIEO sorted-list core.
- Accepts enqueue requests from NUM_ENQ requesters and dequeue requests from one scheduler port.
- Serialises them into one-at-a-time core operations.
- Tracks list occupancy against LIST_SIZE and returns dequeue results to the scheduler.
- Sits between the Shale cell/token logic and the PIEO core, and guards the core against overflow, underflow and hangs.

Parameters:
- ELEM_W, 18: packed SublistElement width (id 3 + slot 3 + rank 4 + send_time 4 + rem_spray_hops_recvd 3 + is_spray 1).
- TIME_LOG, 6: width of the dequeue eligibility time / bucket bitmap.
- LIST_SIZE, 4: maximum number of elements held by the core.
- NUM_ENQ, 2: number of enqueue requesters.
- MAX_WAIT, 15: maximum cycles to wait for core_done before declaring a timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- enq_valid  in  NUM_ENQ  per-requester enqueue request
- enq_elem  in  NUM_ENQ*ELEM_W  requester i occupies bits [i*ELEM_W +: ELEM_W]
- enq_ready  out  NUM_ENQ  one-hot grant pulse; element consumed this cycle
- deq_req  in  1  dequeue request
- deq_time  in  TIME_LOG  curr_time for the dequeue; sampled on accept
- deq_ack  out  1  pulse; dequeue request accepted this cycle
- deq_resp_valid  out  1  pulse; dequeue result valid
- deq_resp_found  out  1  an eligible element was returned
- deq_resp_elem  out  ELEM_W  returned element; 0 when not found
- core_start  out  1  one-cycle operation strobe to the core
- core_is_enq  out  1  1 = enqueue, 0 = dequeue; held from start through done
- core_elem  out  ELEM_W  element to enqueue; held
- core_time  out  TIME_LOG  dequeue time; held
- core_done  in  1  core operation complete
- core_found  in  1  with done: dequeue found an eligible element
- core_elem_out  in  ELEM_W  with done: dequeued element
- occupancy  out  $clog2(LIST_SIZE+1)  current element count
- full  out  1  occupancy == LIST_SIZE
- empty  out  1  occupancy == 0
- timeout_err  out  1  sticky; core failed to respond

Behaviour:
- Reset values: all outputs 0 except empty=1. FSM in IDLE, rr_ptr=0, wait counter 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, dequeue: deq_req has priority over enqueue.
  - deq_req=1 and empty=0: deq_ack=1, latch deq_time, go to ISSUE with core_is_enq=0.
  - deq_req=1 and empty=1: deq_ack=1, go to RESP with found=0; no core operation is issued.
- IDLE, enqueue: when no dequeue is taken, any enq_valid is set and full=0:
  - grant the first valid requester scanning from rr_ptr upward, wrapping at NUM_ENQ;
  - enq_ready[g]=1 for that cycle only; latch enq_elem slice g;
  - rr_ptr <= g+1 mod NUM_ENQ; go to ISSUE with core_is_enq=1.
- IDLE, full: while full=1, enq_ready stays all 0 and requests are held off (not dropped).
- ISSUE: core_start=1 for exactly one cycle; clear the wait counter; go to WAIT.
- WAIT: the wait counter increments each cycle. core_done is sampled only in WAIT; a core_done in ISSUE or IDLE is ignored.
  - On core_done: for enqueue, occupancy+1 and go to IDLE. For dequeue, capture core_found/core_elem_out, occupancy-1 if core_found, go to RESP.
  - If the counter reaches MAX_WAIT with no done: set timeout_err=1. An enqueue is not counted and returns to IDLE. A dequeue goes to RESP with found=0.
  - core_done in the same cycle as expiry: done wins and no error is raised.
- RESP: deq_resp_valid=1 for one cycle with found/elem; go to IDLE.
  - deq_resp_elem is forced to 0 when found=0.
- Latency:
  - accepted dequeue to resp_valid = core latency + 2 cycles;
  - empty dequeue to resp_valid = 1 cycle after ack.
- Throughput: at most one core operation is in flight; every request waits in IDLE.
- Occupancy arithmetic: saturates, never wraps. full/empty are registered alongside occupancy.
- Registering: core_is_enq/core_elem/core_time are registered and stable from ISSUE until leaving WAIT. All grant/ack/resp outputs are registered (Moore).
- timeout_err is cleared only by rst.
- Reset mid-operation: FSM returns to IDLE immediately, occupancy becomes 0, and any in-flight response is discarded.

Test Plan:
- Single enqueue: requester 0 sends elem 18'h2A5C, core_done 3 cycles after start -> enq_ready[0] pulse, core_start one cycle, occupancy 0->1, empty falls.
- Fill and block: 4 enqueues succeed, 5th request held -> full=1, enq_ready stays 0. After one found dequeue, the 5th request is granted.
- Round-robin: both requesters valid continuously -> grants alternate 0,1,0,1; dequeue raised together with enqueue is granted first.
- Empty dequeue: deq_req with occupancy 0 -> deq_ack then next-cycle deq_resp_valid=1, found=0, elem=0, no core_start.
- Found and not-found dequeue: occupancy 2, deq_time=6'h01:
  - core_found=1 with elem 18'h1F0 -> resp found=1 with that element, occupancy 1;
  - core_found=0 -> resp found=0, occupancy unchanged.
- Timeout and reset: core never responds -> after 15 WAIT cycles timeout_err=1 and FSM back in IDLE. Asserting rst during WAIT clears everything, empty=1.
